imem_loader: RTL and testbench

- Byte-stream writer that fills the CPU instruction memory at boot; it is the write-side counterpart of the read-only instruction fetch port.
- Consumes bytes from the UART receiver (valid pulse per byte) carrying a framed program image.
- Assembles little-endian 32-bit words, writes them sequentially into instruction RAM, and holds the RV32I core in reset until a checksum-verified load completes.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-in / word-out bus of the instruction-memory loader.
// master: the loader (consumes UART bytes, drives the RAM write port).
// slave:  the surroundings (UART receiver + instruction RAM).
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a framed program image byte by byte, assembles
// little-endian 32-bit words, writes them into instruction RAM and keeps
// the core in reset until the frame checksum has been verified.
// Frame: HEADER, LEN_LO, LEN_HI, 4*LEN data bytes, CSUM (sum of all but HEADER).
module imem_loader #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  imem_loader_if.master         bus,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     len_lo_q;
  logic [15:0]    len_q;
  logic [7:0]     acc_q;
  logic [1:0]     lane_q;
  logic [23:0]    word_buf_q;
  logic [TW-1:0]  tcnt_q;

  logic           in_frame;
  logic           timeout;
  logic [15:0]    frame_len;
  logic           last_word;
  logic           hdr_hit, len_bad, word_done, csum_ok, csum_bad;

  assign in_frame  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == CSUM);
  assign timeout   = in_frame && !bus.rx_valid && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign frame_len = {bus.rx_data, len_lo_q};
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(len_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and single-cycle event strobes for the datapath
  always_comb begin
    state_d   = state_q;
    hdr_hit   = 1'b0;
    len_bad   = 1'b0;
    word_done = 1'b0;
    csum_ok   = 1'b0;
    csum_bad  = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.rx_valid && bus.rx_data == HEADER) begin
          hdr_hit = 1'b1;
          state_d = LEN_LO;
        end
      end
      LEN_LO: if (bus.rx_valid) state_d = LEN_HI;
      LEN_HI: begin
        if (bus.rx_valid) begin
          if (frame_len == '0) begin
            state_d = CSUM;
          end else if (32'(frame_len) > MAX_WORDS) begin
            len_bad = 1'b1;
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bus.rx_valid && lane_q == 2'd3) begin
          word_done = 1'b1;
          if (last_word) state_d = CSUM;
        end
      end
      CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == acc_q) begin
            csum_ok = 1'b1;
            state_d = DONE;
          end else begin
            csum_bad = 1'b1;
            state_d  = ERROR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = ERROR;
  end

  // Frame datapath: length capture, checksum, word assembly, RAM write, status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      words_loaded  <= '0;
      len_lo_q      <= '0;
      len_q         <= '0;
      acc_q         <= '0;
      lane_q        <= '0;
      word_buf_q    <= '0;
      tcnt_q        <= '0;
    end else begin
      bus.mem_we <= 1'b0;

      if (in_frame) begin
        if (bus.rx_valid) tcnt_q <= '0;
        else              tcnt_q <= tcnt_q + TW'(1);
      end

      if (hdr_hit) begin
        cpu_hold     <= 1'b1;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        words_loaded <= '0;
        acc_q        <= '0;
        lane_q       <= '0;
        tcnt_q       <= '0;
      end

      if (bus.rx_valid) begin
        unique case (state_q)
          LEN_LO: begin
            len_lo_q <= bus.rx_data;
            acc_q    <= acc_q + bus.rx_data;
          end
          LEN_HI: begin
            len_q <= frame_len;
            acc_q <= acc_q + bus.rx_data;
          end
          DATA: begin
            acc_q  <= acc_q + bus.rx_data;
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0:    word_buf_q[7:0]   <= bus.rx_data;
              2'd1:    word_buf_q[15:8]  <= bus.rx_data;
              2'd2:    word_buf_q[23:16] <= bus.rx_data;
              default: ;
            endcase
          end
          default: ;
        endcase
      end

      // Word address is the count of words already written in this frame
      if (word_done) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= words_loaded[ADDR_WIDTH-1:0];
        bus.mem_wdata <= {bus.rx_data, word_buf_q};
        words_loaded  <= words_loaded + (ADDR_WIDTH + 1)'(1);
      end

      if (csum_ok) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end

      if (csum_bad || len_bad || timeout) load_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte, every
// expected RAM write is queued when its last byte is sent and matched
// against the DUT write port by a monitor.
module tb_imem_loader;

  localparam int AW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk;
  logic          reset_n;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int            checks   = 0;
  int            failures = 0;
  wr_t           exp_q[$];
  wr_t           wr;
  logic [31:0]   img[$];

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDR_WIDTH     (AW),
    .HEADER         (8'hA5),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.master),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every mem_we pulse must match the head of the queue
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_we: observed write addr=0x%0h data=0x%0h expected no write",
               bus.mem_addr, bus.mem_wdata);
      end
      if (exp_q.size() != 0) begin
        wr = exp_q.pop_front();
        check("we_addr", 32'(bus.mem_addr), 32'(wr.addr));
        check("we_data", bus.mem_wdata, wr.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends img[] as one frame; csum_err is added to the correct checksum
  task automatic send_frame(input int unsigned gap, input logic [7:0] csum_err);
    logic [15:0] len;
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] w;
    len = 16'(img.size());
    sum = len[7:0] + len[15:8];
    send_byte(8'hA5, gap);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        if (k == 3) exp_q.push_back('{addr: AW'(i), data: w});
        sum = sum + b;
        send_byte(b, gap);
      end
    end
    b = sum + csum_err;
    send_byte(b, gap);
    repeat (2) @(posedge clk);
    #1;
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", bus.mem_wdata,      32'd0);
    check("rst_cpu_hold",  32'(cpu_hold),      32'd1);
    check("rst_done",      32'(load_done),     32'd0);
    check("rst_error",     32'(load_error),    32'd0);
    check("rst_words",     32'(words_loaded),  32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Two-word program; its checksum byte is 0x08
    img = '{32'h0010_0013, 32'h0050_0093};
    send_frame(1, 8'h00);
    check("a_done",      32'(load_done),    32'd1);
    check("a_cpu_hold",  32'(cpu_hold),     32'd0);
    check("a_error",     32'(load_error),   32'd0);
    check("a_words",     32'(words_loaded), 32'd2);
    check("a_hold_addr", 32'(bus.mem_addr), 32'd1);
    check("a_hold_data", bus.mem_wdata,     32'h0050_0093);
    check("a_we_idle",   32'(bus.mem_we),   32'd0);

    // Same frame, checksum sent as 0x0C
    send_frame(1, 8'h04);
    check("b_error",    32'(load_error),   32'd1);
    check("b_done",     32'(load_done),    32'd0);
    check("b_cpu_hold", 32'(cpu_hold),     32'd1);
    check("b_words",    32'(words_loaded), 32'd2);

    // Junk outside a frame is ignored
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h12, 1);
    check("junk_error_kept", 32'(load_error), 32'd1);
    img = '{32'hDEAD_BEEF};
    send_frame(1, 8'h00);
    check("c_done",     32'(load_done),    32'd1);
    check("c_cpu_hold", 32'(cpu_hold),     32'd0);
    check("c_words",    32'(words_loaded), 32'd1);

    // LEN = 1025 exceeds the RAM
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h04, 1);
    repeat (3) @(posedge clk);
    #1;
    check("d_error",    32'(load_error),   32'd1);
    check("d_done",     32'(load_done),    32'd0);
    check("d_cpu_hold", 32'(cpu_hold),     32'd1);
    check("d_words",    32'(words_loaded), 32'd0);

    // Stall after two data bytes: error exactly 100 cycles after the last byte
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    repeat (99) @(posedge clk);
    #1;
    check("to_not_yet", 32'(load_error), 32'd0);
    @(posedge clk); #1;
    check("to_fired",    32'(load_error), 32'd1);
    check("to_cpu_hold", 32'(cpu_hold),   32'd1);
    img = '{32'h0BAD_F00D};
    send_frame(1, 8'h00);
    check("e_done",  32'(load_done),  32'd1);
    check("e_error", 32'(load_error), 32'd0);

    // Reset after the third byte of word 1
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    exp_q.push_back('{addr: AW'(0), data: 32'h1111_1111});
    for (int k = 0; k < 4; k++) send_byte(8'h11, 1);
    for (int k = 0; k < 3; k++) send_byte(8'h22, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_cpu_hold",  32'(cpu_hold),      32'd1);
    check("mr_done",      32'(load_done),     32'd0);
    check("mr_error",     32'(load_error),    32'd0);
    check("mr_words",     32'(words_loaded),  32'd0);
    check("mr_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("mr_mem_wdata", bus.mem_wdata,      32'd0);
    check("mr_drained",   32'(exp_q.size()),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back bytes after reset
    img = '{32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    send_frame(0, 8'h00);
    check("f_done",      32'(load_done),    32'd1);
    check("f_cpu_hold",  32'(cpu_hold),     32'd0);
    check("f_words",     32'(words_loaded), 32'd3);
    check("f_hold_addr", 32'(bus.mem_addr), 32'd2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
